// File: rtl/int_injector.sv
// int_injector: multi-channel interrupt stimulus generator.
// Each channel watches the CPU macroscopic PC and raises its interrupt
// line when the PC reaches the programmed target. The line is lowered
// when the CPU stores to the acknowledge word, or when the channel's
// hold window runs out. Fire limits and re-arming keep one PC visit
// from producing a burst of interrupts.
// Optional feature macro: INT_INJ_TRACE_EN (prints channel enter/exit
// events during simulation; with it undefined the logic is identical).
//
// Config handshake: cfg_we is a single-cycle strobe with no back-pressure.
// The write is taken on the posedge where cfg_we is high, provided
// cfg_ch < NUM_CH, and it overrides every other event on that channel
// in the same cycle.
module int_injector #(
  parameter int          NUM_CH   = 3,
  parameter int          CH_W     = 2,
  parameter logic [31:0] ACK_ADDR = 32'h0000_7f20,
  parameter logic [7:0]  DEF_HOLD = 8'd5,
  parameter logic [7:0]  DEF_MAX  = 8'd1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         macroscopic_pc,
  input  logic [31:0]         m_int_addr,
  input  logic [3:0]          m_int_byteen,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_en,
  input  logic [31:0]         cfg_target,
  input  logic [7:0]          cfg_hold,
  input  logic [7:0]          cfg_max,
  output logic [NUM_CH-1:0]   irq_vec,
  output logic                interrupt,
  output logic [NUM_CH-1:0]   done_vec,
  output logic [2*NUM_CH-1:0] state_dbg
);

  // Channel state encoding, exposed on state_dbg two bits per channel.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Per-channel configuration registers
  logic              en_q     [NUM_CH];
  logic              en_d     [NUM_CH];
  logic [31:0]       target_q [NUM_CH];
  logic [31:0]       target_d [NUM_CH];
  logic [7:0]        hold_q   [NUM_CH];
  logic [7:0]        hold_d   [NUM_CH];
  logic [7:0]        max_q    [NUM_CH];
  logic [7:0]        max_d    [NUM_CH];

  // Per-channel run-time state
  logic [1:0]        state_q  [NUM_CH];
  logic [1:0]        state_d  [NUM_CH];
  logic [7:0]        cnt_q    [NUM_CH];
  logic [7:0]        cnt_d    [NUM_CH];
  logic [7:0]        fires_q  [NUM_CH];
  logic [7:0]        fires_d  [NUM_CH];
  logic              armed_q  [NUM_CH];
  logic              armed_d  [NUM_CH];

  logic [31:0]       pc_masked;
  logic [31:0]       cfg_target_masked;
  logic              ack;
  logic [NUM_CH-1:0] match;

  // Word-aligned views of the PC and target, the ack decode and per-channel matches
  always_comb begin
    pc_masked         = macroscopic_pc & ~32'd3;
    cfg_target_masked = cfg_target & ~32'd3;
    ack               = (|m_int_byteen) && ((m_int_addr & ~32'd3) == ACK_ADDR);
    match             = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = en_q[c] && (pc_masked == target_q[c]);
    end
  end

  // Next-state logic: channel FSM, hold countdown, fire count, re-arm, config load
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      en_d[c]     = en_q[c];
      target_d[c] = target_q[c];
      hold_d[c]   = hold_q[c];
      max_d[c]    = max_q[c];
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      fires_d[c]  = fires_q[c];
      armed_d[c]  = armed_q[c];

      case (state_q[c])
        ST_IDLE: begin
          if (match[c] && armed_q[c]) begin
            state_d[c] = ST_ASSERT;
            cnt_d[c]   = hold_q[c];
            fires_d[c] = (fires_q[c] == 8'hFF) ? fires_q[c] : fires_q[c] + 8'd1;
            armed_d[c] = 1'b0;
          end
        end
        ST_ASSERT: begin
          // Ack and timeout on the same edge collapse into one exit; the
          // fire was already counted on entry so nothing is double-counted.
          if (ack || (cnt_q[c] == 8'd0)) begin
            if ((max_q[c] != 8'd0) && (fires_q[c] == max_q[c])) begin
              state_d[c] = ST_DONE;
            end else begin
              state_d[c] = ST_IDLE;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - 8'd1;
          end
        end
        ST_DONE: begin
          state_d[c] = ST_DONE;
        end
        default: begin
          state_d[c] = ST_IDLE;
        end
      endcase

      // Leaving the target re-arms the channel, so a PC parked on the
      // target fires once rather than on every cycle.
      if ((state_q[c] != ST_ASSERT) && !match[c]) begin
        armed_d[c] = 1'b1;
      end

      // A config write restarts the channel from scratch and beats any
      // trigger, ack or timeout happening on the same edge.
      if (cfg_we && (cfg_ch == CH_W'(c))) begin
        en_d[c]     = cfg_en;
        target_d[c] = cfg_target_masked;
        hold_d[c]   = cfg_hold;
        max_d[c]    = cfg_max;
        state_d[c]  = ST_IDLE;
        cnt_d[c]    = 8'd0;
        fires_d[c]  = 8'd0;
        armed_d[c]  = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en_q[c]     <= 1'b0;
        target_q[c] <= 32'd0;
        hold_q[c]   <= DEF_HOLD;
        max_q[c]    <= DEF_MAX;
        state_q[c]  <= ST_IDLE;
        cnt_q[c]    <= 8'd0;
        fires_q[c]  <= 8'd0;
        armed_q[c]  <= 1'b1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        en_q[c]     <= en_d[c];
        target_q[c] <= target_d[c];
        hold_q[c]   <= hold_d[c];
        max_q[c]    <= max_d[c];
        state_q[c]  <= state_d[c];
        cnt_q[c]    <= cnt_d[c];
        fires_q[c]  <= fires_d[c];
        armed_q[c]  <= armed_d[c];
      end
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    irq_vec   = '0;
    done_vec  = '0;
    state_dbg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq_vec[c]          = (state_q[c] == ST_ASSERT);
      done_vec[c]         = (state_q[c] == ST_DONE);
      state_dbg[2*c +: 2] = state_q[c];
    end
    interrupt = |irq_vec;
  end

`ifdef INT_INJ_TRACE_EN
  // Simulation trace of channel entry into and exit from the asserted state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((state_q[c] != ST_ASSERT) && (state_d[c] == ST_ASSERT)) begin
          $display("%d@%h: int[%0d] <= 1", $time, pc_masked, c);
        end
        if ((state_q[c] == ST_ASSERT) && (state_d[c] != ST_ASSERT)) begin
          $display("%d@%h: int[%0d] <= 0 %s", $time, pc_masked, c,
                   ack ? "ack" : "timeout");
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_injector.sv
// Testbench for int_injector: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model that
// tracks, per channel, how many more cycles the line must stay high.
module tb_int_injector;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int EW     = 2 * NUM_CH;

  logic                clk;
  logic                reset;
  logic [31:0]         macroscopic_pc;
  logic [31:0]         m_int_addr;
  logic [3:0]          m_int_byteen;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic                cfg_en;
  logic [31:0]         cfg_target;
  logic [7:0]          cfg_hold;
  logic [7:0]          cfg_max;
  logic [NUM_CH-1:0]   irq_vec;
  logic                interrupt;
  logic [NUM_CH-1:0]   done_vec;
  logic [2*NUM_CH-1:0] state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  // expected {done_vec, irq_vec} after each modelled edge
  logic [EW-1:0] exp_q[$];

  // behavioural model state
  bit          m_en    [NUM_CH];
  logic [31:0] m_tgt   [NUM_CH];
  int          m_hold  [NUM_CH];
  int          m_max   [NUM_CH];
  int          m_left  [NUM_CH];  // cycles the line still has to stay high
  int          m_fires [NUM_CH];
  bit          m_done  [NUM_CH];
  bit          m_block [NUM_CH];  // fired and PC has not left the target yet

  int_injector #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .ACK_ADDR(32'h0000_7f20),
    .DEF_HOLD(8'd5),
    .DEF_MAX (8'd1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr    (m_int_addr),
    .m_int_byteen  (m_int_byteen),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_en        (cfg_en),
    .cfg_target    (cfg_target),
    .cfg_hold      (cfg_hold),
    .cfg_max       (cfg_max),
    .irq_vec       (irq_vec),
    .interrupt     (interrupt),
    .done_vec      (done_vec),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c]    = 1'b0;
      m_tgt[c]   = 32'd0;
      m_hold[c]  = 5;
      m_max[c]   = 1;
      m_left[c]  = 0;
      m_fires[c] = 0;
      m_done[c]  = 1'b0;
      m_block[c] = 1'b0;
    end
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit            ack_now;
    bit            hit;
    logic [EW-1:0] e;
    ack_now = (m_int_byteen != 4'd0) && ((m_int_addr >> 2) == (32'h0000_7f20 >> 2));
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit = m_en[c] && ((macroscopic_pc >> 2) == (m_tgt[c] >> 2));
      if (cfg_we && (int'(cfg_ch) == c)) begin
        m_en[c]    = cfg_en;
        m_tgt[c]   = {cfg_target[31:2], 2'b00};
        m_hold[c]  = int'(cfg_hold);
        m_max[c]   = int'(cfg_max);
        m_left[c]  = 0;
        m_fires[c] = 0;
        m_done[c]  = 1'b0;
        m_block[c] = 1'b0;
      end else if (m_left[c] > 0) begin
        if (ack_now || m_left[c] == 1) begin
          m_left[c] = 0;
          if (m_max[c] != 0 && m_fires[c] == m_max[c]) m_done[c] = 1'b1;
        end else begin
          m_left[c] = m_left[c] - 1;
        end
      end else begin
        if (!m_done[c] && hit && !m_block[c]) begin
          m_left[c]  = m_hold[c] + 1;
          m_fires[c] = (m_fires[c] >= 255) ? 255 : m_fires[c] + 1;
          m_block[c] = 1'b1;
        end else if (!hit) begin
          m_block[c] = 1'b0;
        end
      end
      e[c]          = (m_left[c] > 0);
      e[NUM_CH + c] = m_done[c];
    end
    exp_q.push_back(e);
  endtask

  // driver: one clock with model update and output comparison
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("irq_vec",   32'(irq_vec),   32'(e[NUM_CH-1:0]));
    check("done_vec",  32'(done_vec),  32'(e[EW-1:NUM_CH]));
    check("interrupt", 32'(interrupt), 32'(|e[NUM_CH-1:0]));
  endtask

  task automatic drive_idle();
    macroscopic_pc = 32'h0000_0ff0;
    m_int_addr     = 32'd0;
    m_int_byteen   = 4'd0;
    cfg_we         = 1'b0;
    cfg_ch         = '0;
    cfg_en         = 1'b0;
    cfg_target     = 32'd0;
    cfg_hold       = 8'd0;
    cfg_max        = 8'd0;
  endtask

  task automatic cfg_write(input int ch, input bit en, input logic [31:0] tgt,
                           input int hold, input int mx);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_en     = en;
    cfg_target = tgt;
    cfg_hold   = 8'(hold);
    cfg_max    = 8'(mx);
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic ack_store(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr   = addr;
    m_int_byteen = be;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq",  32'(irq_vec),   32'd0);
    check("rst_int",  32'(interrupt), 32'd0);
    check("rst_done", 32'(done_vec),  32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int high_cnt;
    int pulses;
    bit prev;

    drive_idle();
    apply_reset();

    // hold timeout: 6-cycle pulse on ch0, then done
    cfg_write(0, 1'b1, 32'h0000_3010, 5, 1);
    macroscopic_pc = 32'h0000_3010;
    high_cnt = 0;
    tick();
    if (irq_vec == 3'b001) high_cnt++;
    macroscopic_pc = 32'h0000_0ff0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (irq_vec == 3'b001) high_cnt++;
    end
    check("hold_len",   32'(high_cnt),    32'd6);
    check("hold_done0", 32'(done_vec[0]), 32'd1);

    // ack clears early, low-address-bit variant of the ack word
    cfg_write(0, 1'b1, 32'h0000_3012, 5, 1);
    check("cfg_clears_done", 32'(done_vec), 32'd0);
    macroscopic_pc = 32'h0000_3010;
    tick();
    macroscopic_pc = 32'h0000_0ff0;
    tick();
    tick();
    ack_store(32'h0000_7f23, 4'b1111);
    tick();
    check("ack_drop", 32'(irq_vec),     32'd0);
    check("ack_done", 32'(done_vec[0]), 32'd1);
    ack_store(32'd0, 4'd0);
    tick();

    // re-arm: PC parked on target fires once; leaving and returning fires again
    cfg_write(1, 1'b1, 32'h0000_4000, 0, 0);
    pulses = 0;
    prev   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      macroscopic_pc = (i < 4 || i == 5) ? 32'h0000_4000 : 32'h0000_0ff0;
      tick();
      if (irq_vec[1] && !prev) pulses++;
      prev = irq_vec[1];
    end
    check("rearm_pulses", 32'(pulses),      32'd2);
    check("rearm_done1",  32'(done_vec[1]), 32'd0);

    // write to a non-existent channel is ignored
    cfg_write(3, 1'b1, 32'h0000_4000, 0, 0);
    macroscopic_pc = 32'h0000_4000;
    tick();
    check("bad_ch_keeps_ch1", 32'(irq_vec[1]), 32'd1);
    macroscopic_pc = 32'h0000_0ff0;
    tick();

    // broadcast ack across two asserted channels
    cfg_write(0, 1'b1, 32'h0000_5000, 10, 1);
    cfg_write(2, 1'b1, 32'h0000_5004, 10, 1);
    macroscopic_pc = 32'h0000_5000;
    tick();
    check("bc_first", 32'(irq_vec), 32'b001);
    macroscopic_pc = 32'h0000_5004;
    tick();
    check("bc_both", 32'(irq_vec), 32'b101);
    macroscopic_pc = 32'h0000_0ff0;
    tick();
    ack_store(32'h0000_7f20, 4'b0001);
    tick();
    check("bc_ack",  32'(irq_vec),  32'b000);
    check("bc_done", 32'(done_vec), 32'b101);
    ack_store(32'd0, 4'd0);
    tick();

    // async reset while ch0 is asserted
    cfg_write(0, 1'b1, 32'h0000_3010, 10, 1);
    macroscopic_pc = 32'h0000_3010;
    tick();
    check("pre_rst_int", 32'(interrupt), 32'd1);
    macroscopic_pc = 32'h0000_0ff0;
    #2;
    reset = 1'b0;
    #1;
    check("async_int", 32'(interrupt), 32'd0);
    check("async_irq", 32'(irq_vec),   32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    macroscopic_pc = 32'h0000_3010;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_no_fire", 32'(interrupt), 32'd0);
    macroscopic_pc = 32'h0000_0ff0;
    tick();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2, 3: macroscopic_pc = 32'h0000_0100 + 32'(4 * $urandom_range(0, 3))
                                       + 32'($urandom_range(0, 3));
          4:          macroscopic_pc = 32'h0000_0200;
          default:    macroscopic_pc = $urandom;
        endcase
      end
      if ($urandom_range(0, 5) == 0) begin
        m_int_addr   = 32'h0000_7f20 + 32'($urandom_range(0, 4));
        m_int_byteen = 4'($urandom_range(0, 15));
      end else begin
        m_int_addr   = $urandom;
        m_int_byteen = 4'd0;
      end
      if ($urandom_range(0, 15) == 0) begin
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'($urandom_range(0, 3));
        cfg_en     = ($urandom_range(0, 4) != 0);
        cfg_target = 32'h0000_0100 + 32'(4 * $urandom_range(0, 3))
                     + 32'($urandom_range(0, 3));
        cfg_hold   = 8'($urandom_range(0, 4));
        cfg_max    = 8'($urandom_range(0, 3));
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    drive_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
